// File: rtl/sad_seq.sv
// rtl/sad_seq.sv - multi-cycle sum-of-absolute-differences responder
module sad_seq #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     pA,
    input  logic [127:0]     pB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      SAD,
    output logic [CNT_W-1:0] count
);

    localparam int N = 16 / LANES;
    localparam logic [4:0] LAST_IDX = 5'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [127:0]     a_q, a_d;
    logic [127:0]     b_q, b_d;
    logic [11:0]      acc_q, acc_d;
    logic [4:0]       idx_q, idx_d;
    logic [11:0]      sad_q, sad_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [11:0]      lane_sum;

    // Sum of |A-B| over the LANES bytes selected by the current lane index.
    always_comb begin
        logic [6:0] base;
        logic [7:0] a_byte;
        logic [7:0] b_byte;
        logic [8:0] diff9;
        logic [7:0] abs8;
        lane_sum = '0;
        base     = '0;
        a_byte   = '0;
        b_byte   = '0;
        diff9    = '0;
        abs8     = '0;
        for (int l = 0; l < LANES; l++) begin
            base   = 7'((int'(idx_q) * LANES + l) * 8);
            a_byte = a_q[base +: 8];
            b_byte = b_q[base +: 8];
            // 9-bit subtract; a set borrow bit means B > A, so negate.
            diff9  = {1'b0, a_byte} - {1'b0, b_byte};
            abs8   = diff9[8] ? (~diff9[7:0] + 8'd1) : diff9[7:0];
            lane_sum = lane_sum + {4'b0000, abs8};
        end
    end

    // Next-state and datapath update for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sad_d   = sad_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = pA;
                    b_d     = pB;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (idx_q == LAST_IDX) begin
                    sad_d   = acc_q + lane_sum;
                    state_d = DONE;
                end else begin
                    acc_d = acc_q + lane_sum;
                    idx_d = idx_q + 5'd1;
                end
            end
            DONE: begin
                // No accept here even on the handshake cycle; IDLE comes first.
                if (out_ready) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            sad_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sad_q   <= sad_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign SAD       = sad_q;
    assign count     = count_q;

endmodule

// File: tb/tb_sad_seq.sv
// tb/tb_sad_seq.sv - scoreboard bench for sad_seq at LANES 4, 1 and 16
module tb_sad_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] pA;
    logic [127:0] pB;
    logic [2:0]   in_ready_v;
    logic [2:0]   out_valid_v;
    logic [11:0]  sad0, sad1, sad2;
    logic [15:0]  cnt0;
    logic [3:0]   cnt1, cnt2;

    always #5 clk = ~clk;

    sad_seq #(.LANES(4), .CNT_W(16)) u_l4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .pA(pA), .pB(pB), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .SAD(sad0), .count(cnt0));
    sad_seq #(.LANES(1), .CNT_W(4)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .pA(pA), .pB(pB), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .SAD(sad1), .count(cnt1));
    sad_seq #(.LANES(16), .CNT_W(4)) u_l16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .pA(pA), .pB(pB), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .SAD(sad2), .count(cnt2));

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          lat_n [3] = '{4, 16, 1};
    logic [11:0] q0 [$];
    logic [11:0] q1 [$];
    logic [11:0] q2 [$];
    logic [15:0] exp_cnt [3];
    logic        pend [3];
    logic [2:0]  ov_prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] get_sad(input int i);
        case (i)
            0:       return sad0;
            1:       return sad1;
            default: return sad2;
        endcase
    endfunction

    function automatic logic [15:0] get_cnt(input int i);
        case (i)
            0:       return cnt0;
            1:       return {12'h000, cnt1};
            default: return {12'h000, cnt2};
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [11:0] pop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic clear_sb();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) begin
            exp_cnt[i] = '0;
            pend[i]    = 1'b0;
        end
        ov_prev = '0;
    endtask

    // Monitor: pops an expected SAD for every output handshake it observes.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (pend[i]) begin
                    pend[i] = 1'b0;
                    chk($sformatf("count[%0d]", i), get_cnt(i), exp_cnt[i]);
                    chk($sformatf("out_valid_drop[%0d]", i), out_valid_v[i], 1'b0);
                    chk($sformatf("in_ready_after[%0d]", i), in_ready_v[i], 1'b1);
                end
                if (out_valid_v[i] && !ov_prev[i])
                    chk($sformatf("latency[%0d]", i), cyc - acc_cyc, lat_n[i]);
                if (out_valid_v[i])
                    chk($sformatf("in_ready_done[%0d]", i), in_ready_v[i], 1'b0);
                if (out_valid_v[i] && out_ready) begin
                    if (qsize(i) == 0) begin
                        chk($sformatf("unexpected_result[%0d]", i), get_sad(i), 12'hFFF);
                        n_fail += (get_sad(i) == 12'hFFF) ? 1 : 0;
                    end else begin
                        chk($sformatf("sad[%0d]", i), get_sad(i), pop(i));
                    end
                    exp_cnt[i] = (i == 0) ? exp_cnt[i] + 16'd1
                                          : ((exp_cnt[i] + 16'd1) & 16'h000F);
                    pend[i] = 1'b1;
                end
                ov_prev[i] = out_valid_v[i];
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (in_ready_v != 3'b111 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", in_ready_v, 3'b111);
    endtask

    task automatic issue(input logic [127:0] a, input logic [127:0] b,
                         input logic [11:0] e, input bit scramble);
        wait_ready();
        pA       = a;
        pB       = b;
        in_valid = 1'b1;
        q0.push_back(e);
        q1.push_back(e);
        q2.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
        if (scramble) begin
            pA = 128'h5A5A_1234_FFFF_0000_8181_7E7E_C3C3_3C3C;
            pB = pA;
        end
        @(negedge clk);
        chk("in_ready_calc", in_ready_v, 3'b000);
    endtask

    task automatic check_idle_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_in_ready[%0d]", tag, i), in_ready_v[i], 1'b1);
            chk($sformatf("%s_out_valid[%0d]", tag, i), out_valid_v[i], 1'b0);
            chk($sformatf("%s_sad[%0d]", tag, i), get_sad(i), 12'h000);
            chk($sformatf("%s_count[%0d]", tag, i), get_cnt(i), 16'h0000);
        end
    endtask

    initial begin
        logic [127:0] a;
        logic [127:0] b;
        int           t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pA        = '0;
        pB        = '0;
        clear_sb();
        repeat (2) @(posedge clk);
        #1;
        check_idle_reset("reset");
        rst = 1'b0;

        // All-zero versus all-0xFF gives the maximum SAD.
        issue('0, '1, 12'hFF0, 1'b0);

        // Identical operands, then the k / 15-k ramp, back to back.
        issue(128'h0123456789ABCDEF_FEDCBA9876543210,
              128'h0123456789ABCDEF_FEDCBA9876543210, 12'h000, 1'b0);
        for (int k = 0; k < 16; k++) begin
            a[8*k +: 8] = 8'(k);
            b[8*k +: 8] = 8'(15 - k);
        end
        issue(a, b, 12'h080, 1'b0);

        // Backpressure with in_valid held high while the result waits.
        wait_ready();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue('0, '1, 12'hFF0, 1'b0);
        t = 0;
        while (!out_valid_v[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_out_valid_seen", out_valid_v[0], 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        pA       = 128'h1;
        pB       = 128'h2;
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid_v[0], 1'b1);
            chk("bp_sad", sad0, 12'hFF0);
            chk("bp_in_ready", in_ready_v[0], 1'b0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Operands changed during CALC must not affect the result.
        issue('0, '1, 12'hFF0, 1'b1);

        // Asynchronous reset between clock edges during CALC.
        issue(128'h00FF_00FF, 128'h0, 12'h000, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        clear_sb();
        #1;
        check_idle_reset("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue({120'h0, 8'h10}, 128'h0, 12'h010, 1'b0);

        // Sixteen more operations so the 4-bit counters wrap to 1.
        for (int i = 1; i <= 16; i++)
            issue({120'h0, 8'(i)}, 128'h0, 12'(i), 1'b0);
        wait_ready();
        repeat (3) @(negedge clk);
        chk("final_count_l4", cnt0, 16'd17);
        chk("final_count_l1", {12'h0, cnt1}, 16'd1);
        chk("final_count_l16", {12'h0, cnt2}, 16'd1);
        chk("sb_drained", qsize(0) + qsize(1) + qsize(2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
